// File: rtl/vericade_btn_pkg.sv
// vericade_btn_pkg
//   Shared constants and types for the push-button conditioning path.
//   N_BTN       : number of physical buttons on the board
//   BTN_*       : bit index of each button within btn_raw/btn_pulse/btn_level
//   rpt_state_t : per-channel auto-repeat state
package vericade_btn_pkg;

  localparam int N_BTN = 5;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEATING = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/btn_channel.sv
// btn_channel
//   One button: 2-flop synchronizer, counter debounce, auto-repeat FSM.
//   Ports:
//     clk    : system clock
//     rst_n  : asynchronous active-low reset
//     raw    : raw asynchronous button level (1 = pressed)
//     pulse  : one-cycle strobe on debounced press and on each repeat
//     level  : debounced held level
module btn_channel import vericade_btn_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       sync;
  logic             deb;
  logic [DB_W-1:0]  db_cnt;
  rpt_state_t       state;
  logic [RPT_W-1:0] tmr;

  logic differ, toggle, rise, fall;

  // The counter holds the number of consecutive disagreeing cycles already
  // seen; the edge that would make it DEBOUNCE_CYCLES flips the state.
  assign differ = sync[1] ^ deb;
  assign toggle = differ && (db_cnt == DB_LAST);
  assign rise   = toggle && !deb;
  assign fall   = toggle && deb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      deb    <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (!differ) begin
        db_cnt <= '0;
      end else if (toggle) begin
        deb    <= ~deb;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign level = deb;

  // Repeat FSM. A debounced release takes priority over a due repeat pulse,
  // so the release cycle never strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (fall) begin
        state <= IDLE;
        tmr   <= '0;
      end else begin
        case (state)
          IDLE: begin
            tmr <= '0;
            if (rise) begin
              pulse <= 1'b1;
              if (REPEAT_EN) state <= HOLD_WAIT;
            end
          end
          HOLD_WAIT: begin
            if (tmr == DLY_LAST) begin
              pulse <= 1'b1;
              tmr   <= '0;
              state <= REPEATING;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          REPEATING: begin
            if (tmr == PER_LAST) begin
              pulse <= 1'b1;
              tmr   <= '0;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            tmr   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions N_BTN raw push-buttons into debounced levels and press/repeat
//   strobes for the game block. Channels are fully independent.
//   Ports:
//     clk       : system clock
//     rst_n     : asynchronous active-low reset
//     btn_raw   : raw asynchronous button levels (1 = pressed)
//     btn_pulse : one-cycle press/repeat strobes, registered
//     btn_level : debounced held levels, registered
module button_conditioner import vericade_btn_pkg::*; #(
  parameter int               N_BTN           = vericade_btn_pkg::N_BTN,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = '0,
  parameter int               REPEAT_DELAY    = 25000000,
  parameter int               REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_MASK[i]),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_raw[i]),
      .pulse (btn_pulse[i]),
      .level (btn_level[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed-vector bench for button_conditioner with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=10, REPEAT_PERIOD=5, REPEAT_MASK=5'b00001.
//   Step k drives btn_raw just before edge k and samples 1 ns after edge k.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn_raw = '0;
  logic [4:0] btn_pulse, btn_level;

  int errs   = 0;
  int checks = 0;
  int pcnt[5];

  always #10 clk = ~clk;

  button_conditioner #(
    .N_BTN           (5),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_MASK     (5'b00001),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_pulse (btn_pulse),
    .btn_level (btn_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [4:0] raw, input logic [4:0] ep, input logic [4:0] el,
                      input string tag, input int k);
    btn_raw = raw;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) if (btn_pulse[i]) pcnt[i]++;
    chk($sformatf("%s k=%0d pulse", tag, k), btn_pulse, ep);
    chk($sformatf("%s k=%0d level", tag, k), btn_level, el);
  endtask

  task automatic clr_cnt;
    for (int i = 0; i < 5; i++) pcnt[i] = 0;
  endtask

  // Leaves rst_n released 1 ns after an edge, so the next edge is edge 1.
  task automatic do_reset;
    btn_raw = '0;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    chk("reset pulse", btn_pulse, 5'b0);
    chk("reset level", btn_level, 5'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_cnt();
  endtask

  initial begin
    logic [4:0] raw, ep, el;
    logic       b;

    // Clean press on DOWN: level 6..25, one pulse at 6, no pulse on release
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      raw = (k <= 20) ? 5'b00010 : 5'b0;
      ep  = (k == 6) ? 5'b00010 : 5'b0;
      el  = (k >= 6 && k <= 25) ? 5'b00010 : 5'b0;
      step(raw, ep, el, "clean", k);
    end
    chk("clean pulse count", pcnt[1], 1);

    // Bounce on LEFT: 2-cycle toggles never qualify; final rise before edge 13
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      if (k <= 12)      b = (((k - 1) / 2) % 2) == 0;
      else if (k <= 22) b = 1'b1;
      else              b = 1'b0;
      raw = {2'b00, b, 2'b00};
      ep  = (k == 18) ? 5'b00100 : 5'b0;
      el  = (k >= 18 && k <= 27) ? 5'b00100 : 5'b0;
      step(raw, ep, el, "bounce", k);
    end
    chk("bounce pulse count", pcnt[2], 1);

    // Glitch on RIGHT: 3 cycles high, one short of qualifying
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      raw = (k <= 3) ? 5'b01000 : 5'b0;
      step(raw, 5'b0, 5'b0, "glitch", k);
    end

    // Auto-repeat on UP (enabled) and CENTER (disabled), P = 6
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      raw   = (k <= 41) ? 5'b10001 : 5'b0;
      ep    = '0;
      ep[0] = (k == 6) || (k >= 16 && k <= 46 && ((k - 16) % 5) == 0);
      ep[4] = (k == 6);
      el    = (k >= 6 && k <= 46) ? 5'b10001 : 5'b0;
      step(raw, ep, el, "repeat", k);
    end
    chk("repeat up count", pcnt[0], 8);
    chk("repeat center count", pcnt[4], 1);

    // Debounced release landing exactly on a due repeat (P+15): no pulse
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      raw = (k <= 15) ? 5'b00001 : 5'b0;
      ep  = (k == 6 || k == 16) ? 5'b00001 : 5'b0;
      el  = (k >= 6 && k <= 20) ? 5'b00001 : 5'b0;
      step(raw, ep, el, "rel_edge", k);
    end
    chk("rel_edge count", pcnt[0], 2);

    // Reset mid-hold at P+12, then held button is a fresh press
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      ep = (k == 6 || k == 16) ? 5'b00001 : 5'b0;
      el = (k >= 6) ? 5'b00001 : 5'b0;
      step(5'b00001, ep, el, "prerst", k);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst pulse", btn_pulse, 5'b0);
    chk("midrst level", btn_level, 5'b0);
    step(5'b00001, 5'b0, 5'b0, "inrst", 1);
    step(5'b00001, 5'b0, 5'b0, "inrst", 2);
    rst_n = 1'b1;
    clr_cnt();
    for (int k = 1; k <= 20; k++) begin
      ep = (k == 6 || k == 16) ? 5'b00001 : 5'b0;
      el = (k >= 6) ? 5'b00001 : 5'b0;
      step(5'b00001, ep, el, "postrst", k);
    end
    chk("postrst count", pcnt[0], 2);

    // Simultaneous press of all buttons
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      ep = (k == 6) ? 5'b11111 : 5'b0;
      el = (k >= 6) ? 5'b11111 : 5'b0;
      step(5'b11111, ep, el, "simul", k);
    end
    for (int i = 0; i < 5; i++) chk($sformatf("simul count ch%0d", i), pcnt[i], 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter: N_BTN, default 5, number of independent button channels.
REQ-002 Parameter: DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), consecutive stable cycles required to accept a level change; legal range is 1 or more.
REQ-003 Parameter: REPEAT_MASK, default 5'b00000, per-button auto-repeat enable.
REQ-004 Parameter: REPEAT_DELAY, default 25000000, cycles from the press pulse to the first repeat pulse.
REQ-005 Parameter: REPEAT_PERIOD, default 5000000, cycles between successive repeat pulses.
REQ-006 Port: clk  input  1  system clock, rising-edge only; the block has one clock.
REQ-007 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-008 Port: btn_raw  input  N_BTN  raw asynchronous push-button levels; 1 means pressed.
REQ-009 Port: btn_pulse  output  N_BTN  one-cycle press/repeat strobes, feeding the game block's btn_pulse input directly.
REQ-010 Port: btn_level  output  N_BTN  debounced held level.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each channel SHALL keep a debounced state and a counter sized clog2(DEBOUNCE_CYCLES+1) bits.
- The counter increments each cycle the synchronized input differs from the debounced state.
- The counter clears to 0 on any cycle they match.
REQ-013 The debounced state SHALL toggle, and the counter clear, on the edge at which the counter would reach DEBOUNCE_CYCLES.
- Latency: a clean raw edge arriving before edge 1 appears on btn_level after edge 2+DEBOUNCE_CYCLES.
REQ-014 Any input reversal shorter than DEBOUNCE_CYCLES cycles SHALL leave btn_level and btn_pulse unchanged.
REQ-015 btn_pulse[i] SHALL be high for exactly one cycle, registered, on the same edge that btn_level[i] rises 0->1.
REQ-016 A 1->0 btn_level transition SHALL never produce a pulse.
REQ-017 Each channel SHALL run a repeat FSM with three states:
- IDLE: exits to HOLD_WAIT when the press pulse fires.
- HOLD_WAIT: counts REPEAT_DELAY cycles, then goes to REPEATING and emits one pulse.
- REPEATING: emits one pulse every REPEAT_PERIOD cycles.
REQ-018 The repeat FSM SHALL only leave IDLE when REPEAT_MASK[i]=1; with the bit clear, a held button yields exactly one pulse.
REQ-019 A debounced release SHALL return the FSM to IDLE from any state in that same cycle, and no pulse SHALL be issued in that cycle.
REQ-020 The repeat timer SHALL be shared across states and sized for max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-021 Channels SHALL be fully independent; any combination of btn_pulse bits MAY be high in the same cycle.
REQ-022 There SHALL be no combinational path from btn_raw to any output.

Reset
REQ-023 While rst_n=0, the following SHALL all be 0 and held there asynchronously:
- synchronizer flops, debounced states and counters
- repeat FSMs (state IDLE) and repeat timers
- btn_pulse and btn_level
REQ-024 A button held through reset deassertion SHALL be treated as a fresh press: exactly one pulse, after edge 2+DEBOUNCE_CYCLES following deassertion.
REQ-025 Reset asserted mid-debounce or mid-repeat SHALL discard all progress; no pulse SHALL be issued for the interrupted event.

Structure
REQ-026 The shared package vericade_btn_pkg SHALL hold:
- N_BTN
- button index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_CENTER=4
- the repeat-state enum typedef (IDLE, HOLD_WAIT, REPEATING)
REQ-027 One channel (synchronizer, debounce, repeat FSM) SHALL be implemented as sub-module btn_channel, instantiated N_BTN times via generate.

Verification
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, REPEAT_MASK=5'b00001, clk 50 MHz.
REQ-028 Clean press:
- Stimulus: btn_raw[1] rises before edge 1 and is held 20 cycles, then released.
- Response: btn_level[1] high after edge 6; btn_pulse[1] high exactly one cycle at edge 6; level falls 6 edges after release, with no pulse.
REQ-029 Bounce:
- Stimulus: btn_raw[2] toggles every 2 cycles for 12 cycles, then holds 1.
- Response: no pulse during the toggling; exactly one pulse 6 edges after the final rising edge.
REQ-030 Glitch:
- Stimulus: btn_raw[3] high for 3 cycles.
- Response: btn_level[3] and btn_pulse[3] stay 0 throughout.
REQ-031 Auto-repeat:
- Stimulus: btn_raw[0] held 40 cycles past its press pulse at cycle P.
- Response: pulses at P, P+10, P+15, P+20, P+25, P+30, P+35, P+40.
- Release then stops pulses immediately.
- The same stimulus on btn_raw[4] gives one pulse only.
REQ-032 Reset mid-hold:
- Stimulus: rst_n driven low at P+12 while btn_raw[0] remains held.
- Response: btn_pulse and btn_level read 0 immediately.
- After rst_n returns to 1, exactly one pulse arrives after edge 6, then repeats resume at +10.
REQ-033 Simultaneous press:
- Stimulus: all five btn_raw bits rise together.
- Response: btn_pulse=5'b11111 for one cycle; scoreboard checks pulse count per channel.
